// File: rtl/mem_responder.sv
// Byte-addressed little-endian memory responder: one request at a time over valid/ready
// request and response channels, with a programmable number of wait cycles per access.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned LATENCY     = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                write_q, write_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [31:0]         mem_q [DEPTH_WORDS];
  logic [ADDR_W-3:0]   word_idx;
  logic [31:0]         word;
  logic [31:0]         byte_shift;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic                legal;
  logic                misaligned;
  logic                acc_err;
  logic [31:0]         load_data;
  logic [3:0]          byte_en;
  logic [31:0]         store_lanes;
  logic                commit;
  logic                mem_we;

  // Access decode works on the registered request so it is stable for the whole WAIT phase.
  assign word_idx   = addr_q[ADDR_W-1:2];
  assign word       = mem_q[word_idx];
  assign byte_shift = word >> {addr_q[1:0], 3'b000};
  assign byte_sel   = byte_shift[7:0];
  assign half_sel   = addr_q[1] ? word[31:16] : word[15:0];

  // NOTE: combinational blocks use blocking '=' and give every output a default first,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    legal      = 1'b0;
    misaligned = 1'b0;
    load_data  = '0;
    case (funct3_q)
      F3_B: begin
        legal     = 1'b1;
        load_data = {{24{byte_sel[7]}}, byte_sel};
      end
      F3_H: begin
        legal      = 1'b1;
        misaligned = addr_q[0];
        load_data  = {{16{half_sel[15]}}, half_sel};
      end
      F3_W: begin
        legal      = 1'b1;
        misaligned = |addr_q[1:0];
        load_data  = word;
      end
      F3_BU: begin
        legal     = !write_q;
        load_data = {24'd0, byte_sel};
      end
      F3_HU: begin
        legal      = !write_q;
        misaligned = addr_q[0];
        load_data  = {16'd0, half_sel};
      end
      default: begin
        legal = 1'b0;
      end
    endcase
    acc_err = !legal || misaligned;
  end

  // Store data is replicated across lanes; the byte enables pick the lanes that land.
  always_comb begin
    byte_en     = 4'b0000;
    store_lanes = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        byte_en     = 4'b0001 << addr_q[1:0];
        store_lanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        byte_en     = addr_q[1] ? 4'b1100 : 4'b0011;
        store_lanes = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        byte_en     = 4'b1111;
        store_lanes = wdata_q;
      end
      default: begin
        byte_en = 4'b0000;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    commit       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          write_d  = req_write_i;
          funct3_d = req_funct3_i;
          addr_d   = req_addr_i;
          wdata_d  = req_wdata_i;
          cnt_d    = 4'(LATENCY);
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = ST_RESP;
          err_d   = acc_err;
          rdata_d = (acc_err || write_q) ? 32'd0 : load_data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) begin
          state_d = ST_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  assign mem_we       = commit && write_q && !acc_err;

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // NOTE: the memory array has no reset; a store dropped by reset never reaches commit
  // because the FSM leaves WAIT asynchronously.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem_q[word_idx][8*i +: 8] <= store_lanes[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: byte-array reference model plus directed vectors.
module tb_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [2:0]  req_funct3_i;
  logic [7:0]  req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mem_m [256];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic        prev_valid = 1'b0;

  mem_responder #(.DEPTH_WORDS(64), .ADDR_W(8), .LATENCY(LAT)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_write_i  (req_write_i),
    .req_funct3_i (req_funct3_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: size from funct3, alignment by modulo, bytes assembled little-endian.
  task automatic model_access(input logic w, input logic [2:0] f3, input logic [7:0] a,
                              input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int size;
    logic [31:0] val;
    bit legal;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err   = !legal || ((int'(a) % size) != 0);
    rd    = 32'd0;
    if (!err) begin
      if (w) begin
        for (int i = 0; i < size; i++) mem_m[int'(a) + i] = wd[8*i +: 8];
      end else begin
        val = 32'd0;
        for (int i = 0; i < size; i++) val = val | (32'(mem_m[int'(a) + i]) << (8 * i));
        if (!f3[2] && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8 * size));
        rd = val;
      end
    end
  endtask

  // Compare process: every cycle a response is presented it must match the model's head entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", {31'd0, resp_valid_o}, 32'd0);
        end else begin
          check("mon_rdata", resp_rdata_o, exp_q[0].rdata);
          check("mon_err", {31'd0, resp_err_o}, {31'd0, exp_q[0].err});
          check("mon_req_ready_in_resp", {31'd0, req_ready_o}, 32'd0);
          if (!prev_valid) check("mon_latency", 32'(cyc - acc_cyc), 32'(LAT + 2));
          if (resp_ready_i) void'(exp_q.pop_front());
        end
      end
      prev_valid = resp_valid_o;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic txn(input string name, input logic w, input logic [2:0] f3, input logic [7:0] a,
                     input logic [31:0] wd, input logic [31:0] lit_rd, input logic lit_err,
                     input int hold, input bit keep_valid);
    exp_t e;
    bit ok;
    req_valid_i  = 1'b1;
    req_write_i  = w;
    req_funct3_i = f3;
    req_addr_i   = a;
    req_wdata_i  = wd;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = req_ready_o;
    end
    if (!ok) begin
      check({name, "_accept_timeout"}, {31'd0, req_ready_o}, 32'd1);
      req_valid_i = 1'b0;
      return;
    end
    acc_cyc = cyc;
    model_access(w, f3, a, wd, e.rdata, e.err);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 30 && !ok; n++) begin
      @(negedge clk);
      ok = resp_valid_o;
    end
    if (!ok) begin
      check({name, "_resp_timeout"}, {31'd0, resp_valid_o}, 32'd1);
      return;
    end
    for (int h = 0; h < hold; h++) begin
      check({name, "_hold_req_ready"}, {31'd0, req_ready_o}, 32'd0);
      check({name, "_hold_valid"}, {31'd0, resp_valid_o}, 32'd1);
      @(posedge clk);
      #1;
      if (keep_valid) begin
        req_valid_i  = 1'b1;
        req_write_i  = 1'b0;
        req_funct3_i = 3'b010;
        req_addr_i   = 8'h10;
        req_wdata_i  = 32'hFFFF_FFFF;
      end
      @(negedge clk);
    end
    resp_ready_i = 1'b1;
    check({name, "_rdata"}, resp_rdata_o, lit_rd);
    check({name, "_err"}, {31'd0, resp_err_o}, {31'd0, lit_err});
    @(posedge clk);
    #1;
    resp_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n        = 1'b0;
    req_valid_i  = 1'b0;
    req_write_i  = 1'b0;
    req_funct3_i = 3'b000;
    req_addr_i   = 8'h00;
    req_wdata_i  = 32'd0;
    resp_ready_i = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
    check("rst_rdata", resp_rdata_o, 32'd0);
    check("rst_err", {31'd0, resp_err_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    txn("sw_10",  1'b1, 3'b010, 8'h10, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 0, 1'b0);
    txn("lw_10",  1'b0, 3'b010, 8'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, 0, 1'b0);

    txn("lb_13",  1'b0, 3'b000, 8'h13, 32'h0, 32'hFFFF_FFDE, 1'b0, 0, 1'b0);
    txn("lbu_13", 1'b0, 3'b100, 8'h13, 32'h0, 32'h0000_00DE, 1'b0, 0, 1'b0);
    txn("lh_10",  1'b0, 3'b001, 8'h10, 32'h0, 32'hFFFF_BEEF, 1'b0, 0, 1'b0);
    txn("lhu_12", 1'b0, 3'b101, 8'h12, 32'h0, 32'h0000_DEAD, 1'b0, 0, 1'b0);

    txn("sb_11",  1'b1, 3'b000, 8'h11, 32'hAAAA_AA55, 32'h0, 1'b0, 0, 1'b0);
    txn("lw_sb",  1'b0, 3'b010, 8'h10, 32'h0, 32'hDEAD_55EF, 1'b0, 0, 1'b0);
    txn("sh_12",  1'b1, 3'b001, 8'h12, 32'hBBBB_1234, 32'h0, 1'b0, 0, 1'b0);
    txn("lw_sh",  1'b0, 3'b010, 8'h10, 32'h0, 32'h1234_55EF, 1'b0, 0, 1'b0);

    txn("lw_mis",  1'b0, 3'b010, 8'h11, 32'h0,         32'h0, 1'b1, 0, 1'b0);
    txn("sh_mis",  1'b1, 3'b001, 8'h13, 32'hFFFF_FFFF, 32'h0, 1'b1, 0, 1'b0);
    txn("ld_011",  1'b0, 3'b011, 8'h10, 32'h0,         32'h0, 1'b1, 0, 1'b0);
    txn("ld_110",  1'b0, 3'b110, 8'h10, 32'h0,         32'h0, 1'b1, 0, 1'b0);
    txn("st_100",  1'b1, 3'b100, 8'h10, 32'hFFFF_FFFF, 32'h0, 1'b1, 0, 1'b0);
    txn("lw_after_err", 1'b0, 3'b010, 8'h10, 32'h0, 32'h1234_55EF, 1'b0, 0, 1'b0);

    txn("lw_hold",   1'b0, 3'b010, 8'h10, 32'h0, 32'h1234_55EF, 1'b0, 5, 1'b1);
    txn("lw_queued", 1'b0, 3'b010, 8'h10, 32'h0, 32'h1234_55EF, 1'b0, 0, 1'b0);

    // Store interrupted by reset while waiting: must never commit.
    req_valid_i  = 1'b1;
    req_write_i  = 1'b1;
    req_funct3_i = 3'b010;
    req_addr_i   = 8'h10;
    req_wdata_i  = 32'h0;
    for (int n = 0; n < 20 && !req_ready_o; n++) @(negedge clk);
    @(negedge clk);
    check("sw_rst_accept", {31'd0, req_ready_o}, 32'd1);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    check("sw_rst_in_wait", {31'd0, req_ready_o}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_req_ready", {31'd0, req_ready_o}, 32'd1);
    check("async_rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
    check("async_rst_rdata", resp_rdata_o, 32'd0);
    check("async_rst_err", {31'd0, resp_err_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    txn("lw_after_rst", 1'b0, 3'b010, 8'h10, 32'h0, 32'h1234_55EF, 1'b0, 0, 1'b0);

    repeat (3) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
